// File: rtl/mat_stream_host.sv
// ---------------------------------------------------------------------------
// mat_stream_host
//
// Stream front-end for a matrix multiplier. Two M x K operand matrices are
// received one element per beat on an input stream (A first, then B,
// row-major). The multiplier is then kicked with a one-cycle start pulse.
// When it signals done, its result is captured. The 64 result elements are
// then returned on an output stream, with a last flag on the final element.
//
// Ports
//   i_clk, i_rstn                clock, asynchronous active-low reset
//   i_s_valid/o_s_ready/i_s_data input element stream
//   o_mat_a, o_mat_b             packed operands (element i at [DATA_LEN*i +: DATA_LEN])
//   o_start                      one-cycle multiplier start pulse
//   i_mat_c, i_done              multiplier result and completion pulse
//   o_m_valid/i_m_ready/o_m_data/o_m_last  output element stream
//   o_state                      current FSM state encoding
// ---------------------------------------------------------------------------
module mat_stream_host #(
    parameter int DATA_LEN = 32,
    parameter int M        = 8,
    parameter int N        = 8,
    parameter int K        = 8,
    parameter int MAT_SIZE = DATA_LEN * K * M
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic                i_s_valid,
    output logic                o_s_ready,
    input  logic [DATA_LEN-1:0] i_s_data,
    output logic [MAT_SIZE-1:0] o_mat_a,
    output logic [MAT_SIZE-1:0] o_mat_b,
    output logic                o_start,
    input  logic [MAT_SIZE-1:0] i_mat_c,
    input  logic                i_done,
    output logic                o_m_valid,
    input  logic                i_m_ready,
    output logic [DATA_LEN-1:0] o_m_data,
    output logic                o_m_last,
    output logic [2:0]          o_state
);

    localparam int ELEMS = M * K;
    localparam int IDX_W = $clog2(ELEMS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ELEMS - 1);

    typedef enum logic [2:0] {
        LOAD_A = 3'd0,
        LOAD_B = 3'd1,
        START  = 3'd2,
        WAIT   = 3'd3,
        SEND   = 3'd4
    } state_t;

    state_t                state_r;
    logic [IDX_W-1:0]      idx_r;
    logic [MAT_SIZE-1:0]   mat_a_r;
    logic [MAT_SIZE-1:0]   mat_b_r;
    logic [MAT_SIZE-1:0]   res_r;
    logic                  s_ready_r;
    logic                  start_r;
    logic                  m_valid_r;
    logic [DATA_LEN-1:0]   m_data_r;
    logic                  m_last_r;

    logic [IDX_W-1:0]      idx_next_s;
    logic [DATA_LEN-1:0]   next_word_s;
    logic                  s_xfer_s;
    logic                  m_xfer_s;

    // Only square M x K tiles pass through this block; N belongs to the
    // multiplier's parameter set and has no role here.
    logic unused_dims_s;
    assign unused_dims_s = (N != K);

    // Next index and the result element that the next output beat presents.
    always_comb begin
        idx_next_s  = idx_r + IDX_W'(1);
        next_word_s = res_r[DATA_LEN*idx_next_s +: DATA_LEN];
        s_xfer_s    = i_s_valid & s_ready_r;
        m_xfer_s    = m_valid_r & i_m_ready;
    end

    // Control FSM. All stream handshake outputs are registered and updated
    // together with the state, so o_s_ready/o_m_valid always match state_r.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_r   <= LOAD_A;
            idx_r     <= '0;
            mat_a_r   <= '0;
            mat_b_r   <= '0;
            res_r     <= '0;
            s_ready_r <= 1'b1;
            start_r   <= 1'b0;
            m_valid_r <= 1'b0;
            m_data_r  <= '0;
            m_last_r  <= 1'b0;
        end else begin
            case (state_r)
                LOAD_A: begin
                    if (s_xfer_s) begin
                        mat_a_r[DATA_LEN*idx_r +: DATA_LEN] <= i_s_data;
                        if (idx_r == LAST_IDX) begin
                            idx_r   <= '0;
                            state_r <= LOAD_B;
                        end else begin
                            idx_r <= idx_next_s;
                        end
                    end
                end
                LOAD_B: begin
                    if (s_xfer_s) begin
                        mat_b_r[DATA_LEN*idx_r +: DATA_LEN] <= i_s_data;
                        if (idx_r == LAST_IDX) begin
                            idx_r     <= '0;
                            state_r   <= START;
                            s_ready_r <= 1'b0;
                            start_r   <= 1'b1;
                        end else begin
                            idx_r <= idx_next_s;
                        end
                    end
                end
                START: begin
                    // start_r is high for exactly the one cycle spent here
                    start_r <= 1'b0;
                    state_r <= WAIT;
                end
                WAIT: begin
                    if (i_done) begin
                        res_r     <= i_mat_c;
                        idx_r     <= '0;
                        state_r   <= SEND;
                        m_valid_r <= 1'b1;
                        m_data_r  <= i_mat_c[DATA_LEN-1:0];
                        m_last_r  <= 1'b0;
                    end
                end
                SEND: begin
                    // Data/last only move on a completed beat, so they hold
                    // steady while the consumer stalls.
                    if (m_xfer_s) begin
                        if (idx_r == LAST_IDX) begin
                            idx_r     <= '0;
                            state_r   <= LOAD_A;
                            m_valid_r <= 1'b0;
                            m_last_r  <= 1'b0;
                            m_data_r  <= '0;
                            s_ready_r <= 1'b1;
                        end else begin
                            idx_r    <= idx_next_s;
                            m_data_r <= next_word_s;
                            m_last_r <= (idx_next_s == LAST_IDX);
                        end
                    end
                end
                default: begin
                    // Unused encodings recover to a clean load.
                    state_r   <= LOAD_A;
                    idx_r     <= '0;
                    s_ready_r <= 1'b1;
                    start_r   <= 1'b0;
                    m_valid_r <= 1'b0;
                    m_last_r  <= 1'b0;
                    m_data_r  <= '0;
                end
            endcase
        end
    end

    assign o_state   = state_r;
    assign o_s_ready = s_ready_r;
    assign o_mat_a   = mat_a_r;
    assign o_mat_b   = mat_b_r;
    assign o_start   = start_r;
    assign o_m_valid = m_valid_r;
    assign o_m_data  = m_data_r;
    assign o_m_last  = m_last_r;

endmodule

// File: tb/tb_mat_stream_host.sv
// ---------------------------------------------------------------------------
// tb_mat_stream_host
//
// Directed bench for mat_stream_host. The bench holds its own copies of A
// and B, computes C = A*B with a behavioural multiplier model, and pushes
// the expected output words to a queue. The queue is popped on every
// output-stream transfer. Inputs are driven and outputs sampled on the
// falling clock edge.
// ---------------------------------------------------------------------------
module tb_mat_stream_host;

    localparam int DL = 32;
    localparam int MS = DL * 64;

    logic          i_clk = 1'b0;
    logic          i_rstn = 1'b0;
    logic          i_s_valid = 1'b0;
    logic          o_s_ready;
    logic [DL-1:0] i_s_data = '0;
    logic [MS-1:0] o_mat_a;
    logic [MS-1:0] o_mat_b;
    logic          o_start;
    logic [MS-1:0] i_mat_c = '0;
    logic          i_done = 1'b0;
    logic          o_m_valid;
    logic          i_m_ready = 1'b0;
    logic [DL-1:0] o_m_data;
    logic          o_m_last;
    logic [2:0]    o_state;

    int errors = 0;
    int checks = 0;
    int start_cnt = 0;

    logic [31:0] a_m [64];
    logic [31:0] b_m [64];
    logic [31:0] c_m [64];
    logic [31:0] exp_q [$];

    mat_stream_host #(.DATA_LEN(DL), .M(8), .N(8), .K(8)) dut (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .i_s_valid (i_s_valid),
        .o_s_ready (o_s_ready),
        .i_s_data  (i_s_data),
        .o_mat_a   (o_mat_a),
        .o_mat_b   (o_mat_b),
        .o_start   (o_start),
        .i_mat_c   (i_mat_c),
        .i_done    (i_done),
        .o_m_valid (o_m_valid),
        .i_m_ready (i_m_ready),
        .o_m_data  (o_m_data),
        .o_m_last  (o_m_last),
        .o_state   (o_state)
    );

    always #5 i_clk = ~i_clk;

    // Count cycles with the start pulse high.
    always @(negedge i_clk) begin
        if (i_rstn && o_start) start_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_mat(input string tag, input logic [MS-1:0] obs, input logic [MS-1:0] exp);
        int bad;
        bad = 0;
        for (int i = 63; i >= 0; i--) begin
            if (obs[32*i +: 32] !== exp[32*i +: 32]) bad = i;
        end
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: element %0d observed=%h expected=%h",
                   tag, bad, obs[32*bad +: 32], exp[32*bad +: 32]);
        end
    endtask

    function automatic logic [MS-1:0] pack(input logic [31:0] m [64]);
        logic [MS-1:0] p;
        p = '0;
        for (int i = 0; i < 64; i++) p[32*i +: 32] = m[i];
        return p;
    endfunction

    // Behavioural multiplier: C = A*B (8x8, signed, truncated to 32 bits).
    // Expected output words are queued in row-major order.
    task automatic model_mult();
        int acc;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                acc = 0;
                for (int k = 0; k < 8; k++) acc += int'(a_m[r*8+k]) * int'(b_m[k*8+c]);
                c_m[r*8+c] = 32'(acc);
                exp_q.push_back(32'(acc));
            end
        end
        i_mat_c = pack(c_m);
    endtask

    // Stream A then B (128 words), optionally with a one-cycle gap before
    // every word and an i_done glitch while B is loading.
    task automatic load_mats(input bit gaps, input bit glitch);
        for (int w = 0; w < 128; w++) begin
            if (gaps) begin
                i_s_valid = 1'b0;
                i_s_data  = $urandom;
                @(negedge i_clk);
            end
            chk("s_ready_load", {31'd0, o_s_ready}, 32'd1);
            i_s_valid = 1'b1;
            if (w < 64) i_s_data = a_m[w];
            else        i_s_data = b_m[w-64];
            i_done = glitch && (w == 80);
            @(negedge i_clk);
            i_done = 1'b0;
            if (w == 63)  chk("state_after_a", {29'd0, o_state}, 32'd1);
            if (w == 126) begin
                chk("state_before_last", {29'd0, o_state}, 32'd1);
                chk("no_early_start", {31'd0, o_start}, 32'd0);
            end
        end
        i_s_valid = 1'b0;
        i_s_data  = '0;
        chk("state_start", {29'd0, o_state}, 32'd2);
        chk("start_pulse", {31'd0, o_start}, 32'd1);
        chk("s_ready_start", {31'd0, o_s_ready}, 32'd0);
        chk_mat("mat_a_pack", o_mat_a, pack(a_m));
        chk_mat("mat_b_pack", o_mat_b, pack(b_m));
    endtask

    // From the START cycle: optional i_done glitch in START, wait a while,
    // then return the modelled product with a done pulse.
    task automatic run_mult(input bit glitch);
        int s0;
        s0 = start_cnt;
        i_done = glitch;
        @(negedge i_clk);
        i_done = 1'b0;
        chk("state_wait", {29'd0, o_state}, 32'd3);
        chk("start_low", {31'd0, o_start}, 32'd0);
        repeat (3) @(negedge i_clk);
        chk("still_wait", {29'd0, o_state}, 32'd3);
        chk("no_valid_wait", {31'd0, o_m_valid}, 32'd0);
        chk_mat("mat_a_hold", o_mat_a, pack(a_m));
        chk_mat("mat_b_hold", o_mat_b, pack(b_m));
        chk("one_start", 32'(start_cnt - s0), 32'd1);
        model_mult();
        i_done = 1'b1;
        @(negedge i_clk);
        i_done = 1'b0;
        for (int i = 0; i < 64; i++) i_mat_c[32*i +: 32] = $urandom;
        chk("state_send", {29'd0, o_state}, 32'd4);
    endtask

    // Consume the output stream until 64 words or stop_at words transferred.
    task automatic drain(input bit rnd, input int stop_at, output int n);
        logic [31:0] held_d;
        logic        held_l;
        logic [31:0] e;
        logic        rdy;
        bit          stalled;
        int          cyc;
        n = 0; stalled = 0; cyc = 0; held_d = '0; held_l = 1'b0;
        while (n < 64 && cyc < 2000) begin
            if (n == stop_at) break;
            chk("m_valid", {31'd0, o_m_valid}, 32'd1);
            if (stalled) begin
                chk("hold_data", o_m_data, held_d);
                chk("hold_last", {31'd0, o_m_last}, {31'd0, held_l});
            end
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rdy) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                chk("m_data", o_m_data, e);
                chk("m_last", {31'd0, o_m_last}, {31'd0, (n == 63)});
                n++;
                stalled = 0;
            end else begin
                held_d  = o_m_data;
                held_l  = o_m_last;
                stalled = 1;
            end
            i_m_ready = rdy;
            @(negedge i_clk);
            cyc++;
        end
        i_m_ready = 1'b0;
    endtask

    task automatic check_idle();
        chk("idle_state", {29'd0, o_state}, 32'd0);
        chk("idle_s_ready", {31'd0, o_s_ready}, 32'd1);
        chk("idle_m_valid", {31'd0, o_m_valid}, 32'd0);
        chk("idle_m_last", {31'd0, o_m_last}, 32'd0);
    endtask

    initial begin
        int n;

        // Reset state
        repeat (3) @(negedge i_clk);
        i_rstn = 1'b1;
        @(negedge i_clk);
        check_idle();
        chk("rst_start", {31'd0, o_start}, 32'd0);
        chk("rst_m_data", o_m_data, 32'd0);
        chk_mat("rst_mat_a", o_mat_a, '0);
        chk_mat("rst_mat_b", o_mat_b, '0);

        // A = identity, B = 1..64; i_done glitches in LOAD_B and START
        for (int i = 0; i < 64; i++) begin
            a_m[i] = (i / 8 == i % 8) ? 32'd1 : 32'd0;
            b_m[i] = 32'(i + 1);
        end
        load_mats(1'b0, 1'b1);
        run_mult(1'b1);
        drain(1'b0, -1, n);
        chk("xfer_count_ident", 32'(n), 32'd64);
        check_idle();

        // Random operands, valid every other cycle, random output back-pressure
        for (int i = 0; i < 64; i++) begin
            a_m[i] = $urandom;
            b_m[i] = $urandom;
        end
        load_mats(1'b1, 1'b0);
        run_mult(1'b0);
        drain(1'b1, -1, n);
        chk("xfer_count_rand", 32'(n), 32'd64);
        check_idle();

        // A all -1, B identity -> every word 0xFFFFFFFF
        for (int i = 0; i < 64; i++) begin
            a_m[i] = 32'hFFFF_FFFF;
            b_m[i] = (i / 8 == i % 8) ? 32'd1 : 32'd0;
        end
        load_mats(1'b0, 1'b0);
        run_mult(1'b0);
        drain(1'b1, -1, n);
        chk("xfer_count_neg", 32'(n), 32'd64);
        check_idle();

        // Reset while the 10th output word is presented
        for (int i = 0; i < 64; i++) begin
            a_m[i] = $urandom;
            b_m[i] = $urandom;
        end
        load_mats(1'b0, 1'b0);
        run_mult(1'b0);
        drain(1'b0, 9, n);
        chk("pre_reset_count", 32'(n), 32'd9);
        i_rstn = 1'b0;
        #1;
        chk("rst_mid_state", {29'd0, o_state}, 32'd0);
        chk("rst_mid_m_valid", {31'd0, o_m_valid}, 32'd0);
        chk("rst_mid_m_data", o_m_data, 32'd0);
        chk("rst_mid_m_last", {31'd0, o_m_last}, 32'd0);
        chk("rst_mid_start", {31'd0, o_start}, 32'd0);
        chk_mat("rst_mid_mat_a", o_mat_a, '0);
        chk_mat("rst_mid_mat_b", o_mat_b, '0);
        @(negedge i_clk);
        i_rstn = 1'b1;
        exp_q.delete();
        @(negedge i_clk);
        check_idle();

        // Next load starts at element 0
        i_s_valid = 1'b1;
        i_s_data  = 32'hCAFE_F00D;
        @(negedge i_clk);
        i_s_data  = 32'h0BAD_F00D;
        @(negedge i_clk);
        i_s_valid = 1'b0;
        chk_mat("restart_idx", o_mat_a, {{(MS-64){1'b0}}, 32'h0BAD_F00D, 32'hCAFE_F00D});
        chk("restart_state", {29'd0, o_state}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mat_stream_host.md
MAT_STREAM_HOST -- requirements
Module: mat_stream_host

Interface
REQ-001 SHALL have parameter DATA_LEN, default 32, element width in bits (signed two's complement).
REQ-002 SHALL have parameters M, N, K, each default 8, matrix dimensions; MAT_SIZE = DATA_LEN*K*M, ELEMS = M*K = 64.
REQ-003 SHALL have one clock; reset is asynchronous and active-low: i_clk  in  1  clock, all logic on rising edge.
REQ-004 SHALL have i_rstn  in  1  asynchronous active-low reset.
REQ-005 SHALL have i_s_valid  in  1, o_s_ready  out  1, i_s_data  in  DATA_LEN: input element stream.
REQ-006 SHALL have o_mat_a, o_mat_b  out  MAT_SIZE: packed operands to the multiplier.
REQ-007 SHALL have o_start  out  1: one-cycle multiplier start pulse.
REQ-008 SHALL have i_mat_c  in  MAT_SIZE and i_done  in  1: multiplier result and completion pulse.
REQ-009 SHALL have o_m_valid  out  1, i_m_ready  in  1, o_m_data  out  DATA_LEN, o_m_last  out  1: output element stream.
REQ-010 SHALL have o_state  out  3: current FSM state encoding.

Function
REQ-011 SHALL implement states LOAD_A=0, LOAD_B=1, START=2, WAIT=3, SEND=4; encodings 5-7 SHALL return to LOAD_A next cycle.
REQ-012 SHALL hold a 6-bit element index idx; a stream transfer occurs when valid and ready are both high on a rising edge.
REQ-013 SHALL drive o_s_ready = 1 only in LOAD_A and LOAD_B, 0 otherwise.
REQ-014 SHALL write each accepted word into bits [DATA_LEN*idx +: DATA_LEN] of the matrix being loaded (row = idx/8, column = idx%8, row-major), then increment idx.
REQ-015 SHALL go LOAD_A -> LOAD_B on transfer with idx = 63, with idx wrapping to 0; LOAD_B -> START the same way.
REQ-016 SHALL assert o_start for exactly the single cycle spent in START; START -> WAIT unconditionally.
REQ-017 SHALL remain in WAIT until i_done = 1, register i_mat_c on that edge into the result buffer, and go to SEND with idx = 0.
REQ-018 SHALL ignore i_done in every state except WAIT; no timeout.
REQ-019 SHALL drive o_m_valid = 1 in SEND only; o_m_data = result buffer element idx; o_m_last = 1 when idx = 63 in SEND.
REQ-020 SHALL hold o_m_data and o_m_last stable while o_m_valid = 1 and i_m_ready = 0.
REQ-021 SHALL increment idx on each output transfer; transfer at idx = 63 SHALL go to LOAD_A with idx = 0.
REQ-022 SHALL keep o_mat_a and o_mat_b unchanged outside LOAD_A/LOAD_B respectively, stable from START through WAIT.
REQ-023 SHALL ignore i_s_valid/i_s_data whenever o_s_ready = 0; no word is dropped or duplicated under valid gaps.
REQ-024 SHALL achieve minimum throughput of one element per cycle on both streams.
REQ-025 SHALL not modify element values (no arithmetic, no sign change).

Reset
REQ-026 SHALL on i_rstn = 0, asynchronously: state = LOAD_A, idx = 0, o_mat_a = o_mat_b = result buffer = 0, o_start = 0, o_m_valid = 0, o_m_last = 0, o_m_data = 0, o_s_ready = 1 after release.
REQ-027 SHALL abandon any transfer in progress on reset mid-operation; partially loaded data SHALL be cleared.

Verification
REQ-028 SHALL test: A = identity, B = elements 1..64 row-major, multiplier model returns A*B -> o_m_data = 1..64 in order, o_m_last only on 64th word, o_start one pulse.
REQ-029 SHALL test: i_s_valid toggling every other cycle over 128 words -> o_mat_a/o_mat_b packing exact, START reached after 128th transfer only.
REQ-030 SHALL test: i_m_ready random 50% -> o_m_data stable while stalled, 64 transfers, returns to LOAD_A (o_state = 0, o_s_ready = 1).
REQ-031 SHALL test: i_done pulsed during LOAD_B and START -> ignored, FSM waits for i_done in WAIT.
REQ-032 SHALL test: i_rstn low at 10th SEND word -> all outputs zero, o_state = 0, next load starts at idx 0.
REQ-033 SHALL test: A all -1 (0xFFFFFFFF), B = identity -> 64 output words all 0xFFFFFFFF.
